// File: rtl/serial_master_pkg.sv
// Shared types for the serial bus initiator: FSM state codes and the command set.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_master_pkg;

`include "includes.svh"

    localparam int SM_DATA_LEN = `DATA_LEN;
    localparam int SM_CMD_LEN  = `CMD_LEN;

    // FSM state codes, kept as plain constants so older tools and dumps
    // see stable numeric values.
    typedef logic [2:0] master_state_t;
    localparam master_state_t IDLE  = 3'd0;
    localparam master_state_t START = 3'd1;
    localparam master_state_t CMD   = 3'd2;
    localparam master_state_t GAP   = 3'd3;
    localparam master_state_t WRITE = 3'd4;
    localparam master_state_t TURN  = 3'd5;
    localparam master_state_t READ  = 3'd6;

    // Command codes understood by the serial_ctrl slaves.
    typedef enum logic [SM_CMD_LEN-1:0] {
        START_SND_CMD = SM_CMD_LEN'(0),  // slave sends data back to us
        START_RCV_CMD = SM_CMD_LEN'(1),  // slave receives our data
        RESET_CMD     = SM_CMD_LEN'(2),
        UPDATE_CMD    = SM_CMD_LEN'(3)
    } ctrl_cmd_t;

    // Where the FSM goes once the post-command gap has elapsed.
    function automatic master_state_t gap_exit(input ctrl_cmd_t op);
        master_state_t nxt;
        case (op)
            START_RCV_CMD: nxt = WRITE;
            START_SND_CMD: nxt = TURN;
            default:       nxt = IDLE;   // reset/update/unknown: no data phase
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/serial_master_if.sv
// Request/response port of the serial bus initiator.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; rd_valid is an unthrottled pulse.
// Optional: bus_err exists only when SERIAL_MASTER_CONTENTION_CHECK_EN is defined.
interface serial_master_if #(
    parameter int DATA_LEN = serial_master_pkg::SM_DATA_LEN,
    parameter int CMD_LEN  = serial_master_pkg::SM_CMD_LEN
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [CMD_LEN-1:0]  cmd_op;
    logic [DATA_LEN-1:0] wr_data;
    logic [DATA_LEN-1:0] rd_data;
    logic                rd_valid;
    logic                busy;
`ifdef SERIAL_MASTER_CONTENTION_CHECK_EN
    logic                bus_err;
`endif

    // Request source side.
    modport master (
        output cmd_valid,
        output cmd_op,
        output wr_data,
`ifdef SERIAL_MASTER_CONTENTION_CHECK_EN
        input  bus_err,
`endif
        input  cmd_ready,
        input  rd_data,
        input  rd_valid,
        input  busy
    );

    // Serial master side.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  wr_data,
`ifdef SERIAL_MASTER_CONTENTION_CHECK_EN
        output bus_err,
`endif
        output cmd_ready,
        output rd_data,
        output rd_valid,
        output busy
    );

endinterface

// File: rtl/includes.svh
`ifndef SERIAL_INCLUDES_SVH
`define SERIAL_INCLUDES_SVH

// Chain-wide widths shared by every serial bus agent.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

`ifndef CMD_LEN
`define CMD_LEN 2
`endif

`endif

// File: rtl/serial_master_shifter.sv
// Parallel-load, MSB-out / serial-in shift register shared by the command,
// write and read phases. Latency: 1 cycle (load/shift take effect at the edge).
// Backpressure: none; load wins over shift.
// Ports: clk, reset (sync, active-low), load/load_val, shift/ser_in, par_out, msb.
module serial_master_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             msb
);

    logic [WIDTH-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= load_val;
        end else if (shift) begin
            sh_q <= {sh_q[WIDTH-2:0], ser_in};
        end
    end

    assign par_out = sh_q;
    assign msb     = sh_q[WIDTH-1];

endmodule

// File: rtl/serial_master.sv
// Initiator of the daisychain single-wire serial bus: start bit, command, write data, read-back.
// Latency: accept to ready 1+CMD_LEN+CMD_GAP[+TURN_GAP]+DATA_LEN+1 cycles (no data phase: 1+CMD_LEN+CMD_GAP+1).
// Backpressure: cmd_ready high only in IDLE; cmd_valid while busy is ignored.
// Ports: clk, reset (sync, active-low), data_inout (bus line), req (serial_master_if.slave).
// Optional: SERIAL_MASTER_CONTENTION_CHECK_EN adds the sticky req.bus_err flag.
module serial_master
    import serial_master_pkg::*;
#(
    parameter int DATA_LEN = SM_DATA_LEN,
    parameter int CMD_LEN  = SM_CMD_LEN,
    parameter int CMD_GAP  = 2,
    parameter int TURN_GAP = 2,
    parameter int CNT_LEN  = $clog2(DATA_LEN + 1) + 1
) (
    input  logic            clk,
    input  logic            reset,
    inout  wire             data_inout,
    serial_master_if.slave  req
);

    master_state_t       state;
    master_state_t       state_nxt;
    logic [CNT_LEN-1:0]  cnt;
    ctrl_cmd_t           op_reg;
    logic [DATA_LEN-1:0] wr_reg;
    logic [DATA_LEN-1:0] rd_reg;
    logic                rd_vld_q;
    logic                line_drv;
    logic                line_oe;
    logic                drv_nxt;
    logic                oe_nxt;
    logic                accept;
    logic                read_done;

    logic                sh_load;
    logic [DATA_LEN-1:0] sh_val;
    logic                sh_shift;
    logic [DATA_LEN-1:0] sh_par;
    logic                sh_msb;

    assign accept        = req.cmd_valid && req.cmd_ready;
    assign req.cmd_ready = (state == IDLE);
    assign req.busy      = (state != IDLE);
    assign req.rd_data   = rd_reg;
    assign req.rd_valid  = rd_vld_q;

    // Line is released only while the slave owns it (turnaround and read).
    assign data_inout = line_oe ? line_drv : 1'bz;

    // Next state: each phase lasts a fixed number of cycles counted by cnt.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req.cmd_valid)                     state_nxt = START;
            START:                                        state_nxt = CMD;
            CMD:   if (cnt == CNT_LEN'(CMD_LEN - 1))      state_nxt = GAP;
            GAP:   if (cnt == CNT_LEN'(CMD_GAP - 1))      state_nxt = gap_exit(op_reg);
            WRITE: if (cnt == CNT_LEN'(DATA_LEN - 1))     state_nxt = IDLE;
            TURN:  if (cnt == CNT_LEN'(TURN_GAP - 1))     state_nxt = READ;
            READ:  if (cnt == CNT_LEN'(DATA_LEN - 1))     state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    assign read_done = (state == READ) && (state_nxt == IDLE);

    // The line register is loaded from the state being entered, so the
    // bit on the wire always lines up with the state it belongs to.
    always_comb begin
        drv_nxt = 1'b0;
        oe_nxt  = 1'b1;
        case (state_nxt)
            START:       drv_nxt = 1'b1;
            CMD, WRITE:  drv_nxt = sh_msb;
            TURN, READ:  oe_nxt  = 1'b0;
            default:     drv_nxt = 1'b0;
        endcase
    end

    // Shifter use: the command is loaded left-aligned at accept; write data
    // is loaded during the gap so its MSB is ready when WRITE is entered.
    // Bits shifted in while sending are junk and get overwritten by the
    // next load.
    always_comb begin
        sh_load = 1'b0;
        sh_val  = '0;
        if (accept) begin
            sh_load = 1'b1;
            sh_val  = DATA_LEN'(req.cmd_op) << (DATA_LEN - CMD_LEN);
        end else if ((state == CMD) && (state_nxt == GAP)) begin
            sh_load = 1'b1;
            sh_val  = wr_reg;
        end
    end

    assign sh_shift = (state_nxt == CMD) || (state_nxt == WRITE) || (state == READ);

    serial_master_shifter #(
        .WIDTH (DATA_LEN)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .load_val (sh_val),
        .shift    (sh_shift),
        .ser_in   (data_inout),
        .par_out  (sh_par),
        .msb      (sh_msb)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_reg   <= START_SND_CMD;
            wr_reg   <= '0;
            rd_reg   <= '0;
            rd_vld_q <= 1'b0;
            line_drv <= 1'b0;
            line_oe  <= 1'b1;
        end else begin
            state    <= state_nxt;
            line_drv <= drv_nxt;
            line_oe  <= oe_nxt;
            rd_vld_q <= read_done;

            if ((state_nxt != state) || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                op_reg <= ctrl_cmd_t'(req.cmd_op);
                wr_reg <= req.wr_data;
            end

            // Final sample goes straight into the result alongside the
            // seven already collected in the shifter.
            if (read_done) begin
                rd_reg <= {sh_par[DATA_LEN-2:0], data_inout};
            end
        end
    end

`ifdef SERIAL_MASTER_CONTENTION_CHECK_EN
    logic bus_err_q;

    // Wire read back the same cycle must match what we drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else if (accept) begin
            bus_err_q <= 1'b0;
        end else if (((state == START) || (state == CMD) || (state == WRITE)) &&
                     (data_inout != line_drv)) begin
            bus_err_q <= 1'b1;
        end
    end

    assign req.bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_serial_master.sv
// Bench for serial_master: directed literal cases plus randomized traffic
// against a cycle-by-cycle expected-waveform model built from the bus rules.
module tb_serial_master;
    import serial_master_pkg::*;

    localparam int DL = SM_DATA_LEN;
    localparam int CL = SM_CMD_LEN;
    localparam int CG = 2;
    localparam int TG = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    wire  line;
    logic tb_oe  = 1'b0;
    logic tb_bit = 1'b0;
    logic [DL-1:0] slv_data = '0;
    logic chk_en = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;

    assign line = tb_oe ? tb_bit : 1'bz;

    serial_master_if bus ();

    serial_master #(
        .CMD_GAP  (CG),
        .TURN_GAP (TG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_inout (line),
        .req        (bus)
    );

    always #5 clk = ~clk;

    // One expected bus cycle: busy flag, who owns the line, line value,
    // rd_valid pulse and the read result it carries.
    typedef struct {
        bit          busy;
        bit          drv;
        bit          val;
        bit          rv;
        logic [DL-1:0] rd;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic [DL-1:0] model_rd = '0;

    function automatic exp_t mk(input bit busy, input bit drv, input bit val,
                                input bit rv, input logic [DL-1:0] rd);
        exp_t e;
        e.busy = busy;
        e.drv  = drv;
        e.val  = val;
        e.rv   = rv;
        e.rd   = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Whole transaction as a list of cycles following the accept cycle.
    task automatic build(input logic [CL-1:0] op, input logic [DL-1:0] wd,
                         input logic [DL-1:0] sd);
        q.push_back(mk(1, 1, 1, 0, '0));
        for (int i = CL - 1; i >= 0; i--) q.push_back(mk(1, 1, op[i], 0, '0));
        for (int i = 0; i < CG; i++) q.push_back(mk(1, 1, 0, 0, '0));
        if (op == START_RCV_CMD) begin
            for (int i = DL - 1; i >= 0; i--) q.push_back(mk(1, 1, wd[i], 0, '0));
        end else if (op == START_SND_CMD) begin
            // Slave drives the inverse of its MSB during turnaround so an
            // early sample would corrupt the result.
            for (int i = 0; i < TG; i++) q.push_back(mk(1, 0, ~sd[DL-1], 0, '0));
            for (int i = DL - 1; i >= 0; i--) q.push_back(mk(1, 0, sd[i], 0, '0));
            q.push_back(mk(0, 1, 0, 1, sd));
        end
    endtask

    // Model and bench-side slave: advance one expected cycle per clock.
    initial begin
        cur = mk(0, 1, 0, 0, '0);
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                q.delete();
                cur = mk(0, 1, 0, 0, '0);
                model_rd = '0;
            end else begin
                if (!cur.busy && bus.cmd_valid) build(bus.cmd_op, bus.wr_data, slv_data);
                if (q.size() != 0) cur = q.pop_front();
                else cur = mk(0, 1, 0, 0, '0);
                if (cur.rv) model_rd = cur.rd;
            end
            tb_oe  = cur.busy && !cur.drv;
            tb_bit = cur.val;
        end
    end

    // Compare every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !cur.busy});
                chk("busy",      {31'd0, bus.busy},      {31'd0, cur.busy});
                chk("rd_valid",  {31'd0, bus.rd_valid},  {31'd0, cur.rv});
                chk("rd_data",   32'(bus.rd_data),       32'(model_rd));
                chk("line",      {31'd0, line},          {31'd0, cur.val});
`ifdef SERIAL_MASTER_CONTENTION_CHECK_EN
                chk("bus_err",   {31'd0, bus.bus_err},   32'd0);
`endif
            end
        end
    end

    // Issue one request from idle and watch it until cmd_ready returns.
    task automatic run_req(input ctrl_cmd_t op, input logic [DL-1:0] wd,
                           input logic [DL-1:0] sd, output int lat,
                           output logic [15:0] lines, output int rvs);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.wr_data   = wd;
        slv_data      = sd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~bus.cmd_op;
        bus.wr_data   = ~bus.wr_data;
        lat   = 1;
        lines = '0;
        rvs   = 0;
        while (!bus.cmd_ready && lat < 40) begin
            lines = {lines[14:0], line};
            if (bus.rd_valid) rvs++;
            @(negedge clk);
            lat++;
        end
        if (bus.rd_valid) rvs++;
        @(negedge clk);
        if (bus.rd_valid) rvs++;
    endtask

    initial begin
        int lat;
        int rvs;
        logic [15:0] lines;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.wr_data   = '0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",    {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy",     {31'd0, bus.busy},      32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid},  32'd0);
        chk("rst_rd_data",  32'(bus.rd_data),       32'd0);
        chk("rst_line",     {31'd0, line},          32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Write A5: start, cmd 01, gap 00, data 10100101.
        run_req(START_RCV_CMD, 8'hA5, 8'h00, lat, lines, rvs);
        chk("wr_latency", 32'(lat), 32'd14);
        chk("wr_lines",   32'(lines[12:0]), 32'(13'b1_01_00_10100101));
        chk("wr_rd_valid_cnt", 32'(rvs), 32'd0);

        // Read 3C: start, cmd 00, gap 00, turnaround 11, slave data.
        run_req(START_SND_CMD, 8'h5A, 8'h3C, lat, lines, rvs);
        chk("rd_latency", 32'(lat), 32'd16);
        chk("rd_valid_cnt", 32'(rvs), 32'd1);
        chk("rd_result", 32'(bus.rd_data), 32'h3C);
        chk("rd_lines", 32'(lines[14:0]), 32'(15'b1_00_00_11_00111100));

        // Update: start, cmd 11, gap 00, no data phase.
        run_req(UPDATE_CMD, 8'hFF, 8'hFF, lat, lines, rvs);
        chk("upd_latency", 32'(lat), 32'd6);
        chk("upd_lines", 32'(lines[4:0]), 32'(5'b11100));
        chk("upd_rd_valid_cnt", 32'(rvs), 32'd0);
        chk("upd_rd_hold", 32'(bus.rd_data), 32'h3C);

        // Reset in the middle of the write data phase.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = START_RCV_CMD;
        bus.wr_data   = 8'hFF;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_line",  {31'd0, line},          32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
        chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("mid_rst_rv",    {31'd0, bus.rd_valid},  32'd0);
        chk("mid_rst_rd",    32'(bus.rd_data),       32'd0);
        @(negedge clk);
        chk("mid_rst_rv2",   {31'd0, bus.rd_valid},  32'd0);

        // Random traffic: valid held while busy, op/data churn every cycle,
        // occasional one-cycle resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!reset) reset = 1'b1;
            else reset = ($urandom_range(0, 199) != 0);
            if (bus.cmd_ready) bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_op  = CL'($urandom);
            bus.wr_data = DL'($urandom);
            slv_data    = DL'($urandom);
        end
        @(negedge clk);
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("drain_idle", {31'd0, bus.cmd_ready}, 32'd1);

`ifdef SERIAL_MASTER_CONTENTION_CHECK_EN
        chk_en = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = START_RCV_CMD;
        bus.wr_data   = 8'hFF;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        force line = 1'b0;
        @(negedge clk);
        release line;
        chk("bus_err_set", {31'd0, bus.bus_err}, 32'd1);
        lat = 0;
        while (!bus.cmd_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bus_err_sticky", {31'd0, bus.bus_err}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = UPDATE_CMD;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bus_err_clr", {31'd0, bus.bus_err}, 32'd0);
        repeat (10) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
